// File: rtl/fft_dac_pkg.sv
// rtl/fft_dac_pkg.sv - commands, frame width, FSM states and address helper for the SPI DAC writer
package fft_dac_pkg;

  localparam logic [3:0] CMD_WR_UPD = 4'b0011;
  localparam logic [3:0] CMD_WR_IN  = 4'b0001;
  localparam int         FRAME_W    = 24;

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, GAP, LDAC} state_t;

  function automatic logic [3:0] ch2addr(input logic [1:0] ch);
    return 4'b0001 << ch;
  endfunction

endpackage

// File: rtl/fft_dac_sclk_gen.sv
// rtl/fft_dac_sclk_gen.sv - SCLK divider with rise/fall strobes aligned to the toggling edge
module fft_dac_sclk_gen #(
  parameter int DIV = 12
) (
  input  logic iCLK,
  input  logic iRESET,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;
  logic          tc;

  assign tc   = en && (cnt == CW'(DIV - 1));
  assign rise = tc && !sclk;
  assign fall = tc && sclk;

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      cnt  <= '0;
      sclk <= 1'b1;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b1;
    end else if (tc) begin
      cnt  <= '0;
      sclk <= !sclk;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/fft_dac_mc.sv
// rtl/fft_dac_mc.sv - multi-channel AD5686-class SPI DAC writer with round-robin service and optional LDAC
module fft_dac_mc
  import fft_dac_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CH_NUM = 4,
  parameter int DIV    = 12,
  parameter int MODE   = 0,
  localparam int CH_W  = $clog2(CH_NUM) + 1
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iEN,
  input  logic              iVALID,
  input  logic [CH_W-1:0]   iCH,
  input  logic [DATA_W-1:0] iDATA,
  output logic              oBUSY,
  output logic              oDONE,
  output logic              oOVERRUN,
  output logic              oDAC_DATA,
  output logic              oDAC_CS,
  output logic              oDAC_CLK,
  output logic              oDAC_LDAC
);

  localparam int         CHI_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int         FW    = FRAME_W + DATA_W - 16;
  localparam int         BW    = $clog2(FW + 1);
  localparam int         WW    = $clog2(DIV) + 1;
  localparam logic [3:0] CMD   = (MODE != 0) ? CMD_WR_IN : CMD_WR_UPD;

  state_t            state, state_n;
  logic [DATA_W-1:0] hold [CH_NUM];
  logic [CH_NUM-1:0] pend, set_v, clr_v;
  logic [CHI_W-1:0]  last, sel, idx;
  logic [FW-1:0]     frame;
  logic [BW-1:0]     bitcnt;
  logic [WW-1:0]     wcnt;
  logic              sclk_rise, sclk_fall, legal, found, go, last_bit, wait_done, overrun;

  assign legal     = iVALID && (iCH < CH_W'(CH_NUM));
  assign go        = iEN && (|pend);
  assign last_bit  = sclk_rise && (bitcnt == BW'(FW));
  assign wait_done = (wcnt == WW'(DIV - 1));
  assign overrun   = |(set_v & pend & ~clr_v);
  assign oBUSY     = (state != IDLE);
  assign oDAC_DATA = frame[FW-1];

  fft_dac_sclk_gen #(.DIV(DIV)) u_sclk (
    .iCLK  (iCLK),
    .iRESET(iRESET),
    .en    (state == SHIFT),
    .sclk  (oDAC_CLK),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  // Search starts just after the last served channel and wraps.
  always_comb begin
    sel   = last;
    idx   = last;
    found = 1'b0;
    for (int i = 1; i <= CH_NUM; i++) begin
      idx = CHI_W'((int'(last) + i) % CH_NUM);
      if (!found && pend[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    set_v = '0;
    clr_v = '0;
    for (int c = 0; c < CH_NUM; c++) begin
      set_v[c] = legal && (iCH == CH_W'(c));
      clr_v[c] = (state == LOAD) && (sel == CHI_W'(c));
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (go) state_n = LOAD;
      LOAD:    state_n = SHIFT;
      SHIFT:   if (last_bit) state_n = GAP;
      GAP:     if (wait_done) state_n = go ? LOAD : ((MODE != 0) ? LDAC : IDLE);
      LDAC:    if (wait_done) state_n = go ? LOAD : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) state <= IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      for (int c = 0; c < CH_NUM; c++) hold[c] <= '0;
    end else begin
      for (int c = 0; c < CH_NUM; c++) if (set_v[c]) hold[c] <= iDATA;
    end
  end

  // A fresh capture on the channel being loaded re-arms its pending bit.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      pend      <= '0;
      last      <= CHI_W'(CH_NUM - 1);
      frame     <= '0;
      bitcnt    <= '0;
      wcnt      <= '0;
      oDAC_CS   <= 1'b1;
      oDAC_LDAC <= 1'b1;
      oDONE     <= 1'b0;
      oOVERRUN  <= 1'b0;
    end else begin
      pend      <= (pend & ~clr_v) | set_v;
      oOVERRUN  <= overrun;
      oDONE     <= (state == SHIFT) && (state_n == GAP);
      oDAC_CS   <= (state_n != SHIFT);
      oDAC_LDAC <= (state_n != LDAC);
      if (state_n != state)                  wcnt <= '0;
      else if (state == GAP || state == LDAC) wcnt <= wcnt + WW'(1);
      if (state == LOAD) begin
        frame  <= {CMD, ch2addr(2'(sel)), hold[sel]};
        last   <= sel;
        bitcnt <= '0;
      end else if (state == SHIFT) begin
        if (sclk_fall) bitcnt <= bitcnt + BW'(1);
        if (sclk_rise) frame <= frame << 1;
        if (last_bit)  bitcnt <= '0;
      end
    end
  end

endmodule
